efuse_ctrl: RTL and testbench
=============================

// Module: efuse_ctrl
// PURPOSE
//  Sequencer for the 128x8 eFuse macro (CSB/STROBE/LOAD/VDDQ/PGENB/A/Q pins).
//  Takes single-byte read/program commands over a valid/ready port, drives macro
//  mode pins and STROBE with programmable setup/pulse/hold timing, returns a 1-cycle response.
//  Sits between the OTP register/boot logic and the macro; it is the only driver of macro pins.
// PARAMETERS
//  NUM_BYTES  128  implemented bytes; cmd_addr >= NUM_BYTES is rejected
//  T_SU       2    cycles pins/address stable before STROBE rises (>=1)
//  T_RD       4    STROBE high cycles for read (>=1)
//  T_PGM      100  STROBE high cycles per programmed bit (>=1)
//  T_HLD      2    cycles pins held after STROBE falls (>=1)
// PORTS
//  clk           in   1   single clock, all logic on rising edge
//  rst           in   1   synchronous, active-high reset
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high only in IDLE; transfer = valid & ready
//  cmd_write     in   1   1 = program, 0 = read
//  cmd_addr      in   7   byte address
//  cmd_wdata     in   8   bits to blow (1 = program bit; 0 bits untouched)
//  rsp_valid     out  1   1-cycle pulse, no backpressure
//  rsp_rdata     out  8   read data (0 for writes/errors); held until next rsp
//  rsp_err       out  1   address out of range; qualified by rsp_valid
//  busy          out  1   ~cmd_ready
//  efuse_csb     out  1   macro chip select, active low
//  efuse_strobe  out  1   macro strobe
//  efuse_load    out  1   1 in read mode, 0 otherwise
//  efuse_vddq    out  1   program supply enable; 1 only in program mode
//  efuse_pgenb   out  1   program enable, active low
//  efuse_a       out  10  {bit[2:0], byte[6:0]}
//  efuse_q       in   8   macro read data, valid after STROBE falls
// BEHAVIOUR
//  - Reset/idle pins: csb=1 strobe=0 load=0 vddq=0 pgenb=1 a=0; rsp_valid=0 rsp_rdata=0
//    rsp_err=0 cmd_ready=1. All outputs registered.
//  - Read mode pins: csb=0 load=1 vddq=0 pgenb=1. Program mode: csb=0 load=0 vddq=1 pgenb=0.
//    Never both; mode pins change only while strobe=0.
//  - FSM: IDLE -> SETUP(T_SU) -> STROBE(T_RD|T_PGM) -> HOLD(T_HLD) -> [SETUP next bit] -> DONE -> IDLE.
//  - Handshake cycle c0 latches cmd; mode pins + efuse_a driven from c1.
//  - Read: strobe high T_RD cycles; efuse_q sampled on last HOLD cycle; rsp_valid at
//    c0+1+T_SU+T_RD+T_HLD (=c9 default) with rsp_rdata=efuse_q.
//  - Program: one SETUP/STROBE/HOLD per set bit of cmd_wdata, ascending bit order;
//    efuse_a[9:7] updated at SETUP entry; mode pins stay asserted between bits.
//    rsp_valid at c0+1+k*(T_SU+T_PGM+T_HLD), k = popcount(wdata).
//  - wdata==0 or addr>=NUM_BYTES: no pin activity, DONE at c1 (rsp_err=1 only for addr).
//  - DONE: pins return to idle values same cycle rsp_valid=1; cmd_ready=1 next cycle
//    (back-to-back command accepted the cycle after rsp_valid).
//  - cmd_valid during busy ignored; cmd fields sampled only at handshake.
//  - rst mid-operation: next edge all outputs to reset values (strobe drops at once),
//    no response issued, partially programmed byte is not reported.
//  - Timer width $clog2(max(T_*)+1); counters load T-1 and count down to 0.
// STRUCTURE
//  - efuse_pkg: state enum (IDLE,SETUP,STROBE,HOLD,DONE), mode pin-set constants
//    (PINS_IDLE/PINS_READ/PINS_PGM), bit-index typedef, efuse_a packing function.
//  - Sub-module efuse_timer: loadable down-counter with zero flag, one instance shared by all phases.
//  - Next-set-bit search: combinational priority encoder on remaining-bits mask.
// TESTING (bench with macro behavioural model, default params unless noted)
//  1 read addr 1 after reset -> rsp_valid at c9, rsp_rdata=8'hFF, strobe high exactly 4 cycles, load=1 vddq=0
//  2 program addr 0 wdata 8'hA5 -> 4 strobes of 100 cycles, a[9:7]=0,2,5,7, rsp at c1+4*104; read addr 0 -> 8'hA5
//  3 program addr 2 wdata 8'h00 -> no csb/strobe activity, rsp_valid at c1, rsp_err=0
//  4 NUM_BYTES=10, read addr 10 -> rsp_valid c1, rsp_err=1, rsp_rdata=0, csb stays 1
//  5 rst during program STROBE -> next cycle strobe=0 csb=1 vddq=0 pgenb=1, no rsp; cmd_ready=1 after release
//  6 cmd_valid held through busy with second cmd -> cmd_ready=0 until after rsp; second cmd accepted cycle after rsp_valid

Source files
------------

// File: rtl/efuse_pkg.sv
// Shared types and helpers for the eFuse sequencer: FSM states, mode pin sets,
// bit-index type and the macro address packing.
package efuse_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Static mode pins of the macro (strobe and address are handled separately).
    typedef struct packed {
        logic csb;
        logic load;
        logic vddq;
        logic pgenb;
    } pins_t;

    localparam pins_t PINS_IDLE = '{csb: 1'b1, load: 1'b0, vddq: 1'b0, pgenb: 1'b1};
    localparam pins_t PINS_READ = '{csb: 1'b0, load: 1'b1, vddq: 1'b0, pgenb: 1'b1};
    localparam pins_t PINS_PGM  = '{csb: 1'b0, load: 1'b0, vddq: 1'b1, pgenb: 1'b0};

    // Index of a bit inside the 8-bit fuse byte.
    typedef logic [2:0] bit_idx_t;

    // Macro address layout: bit index in the upper field, byte address below.
    function automatic logic [9:0] efuse_a_pack(input bit_idx_t bit_idx,
                                                input logic [6:0] byte_addr);
        return {bit_idx, byte_addr};
    endfunction

    // Largest of the four phase lengths; sizes the shared phase timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/efuse_timer.sv
// Loadable down-counter shared by all sequencer phases. A phase of N cycles
// loads N-1 on entry; the zero flag marks the last cycle of the phase.
module efuse_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/efuse_ctrl.sv
// Sequencer for the 128x8 eFuse macro. Accepts one read/program command at a
// time, walks the macro through SETUP/STROBE/HOLD phases (once per set bit when
// programming) and returns a single-cycle response. All outputs are registered.
module efuse_ctrl
    import efuse_pkg::*;
#(
    parameter int NUM_BYTES = 128,
    parameter int T_SU      = 2,
    parameter int T_RD      = 4,
    parameter int T_PGM     = 100,
    parameter int T_HLD     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       efuse_csb,
    output logic       efuse_strobe,
    output logic       efuse_load,
    output logic       efuse_vddq,
    output logic       efuse_pgenb,
    output logic [9:0] efuse_a,
    input  logic [7:0] efuse_q
);

    localparam int T_MAX = max4(T_SU, T_RD, T_PGM, T_HLD);
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] SU_LOAD  = TW'(T_SU - 1);
    localparam logic [TW-1:0] RD_LOAD  = TW'(T_RD - 1);
    localparam logic [TW-1:0] PGM_LOAD = TW'(T_PGM - 1);
    localparam logic [TW-1:0] HLD_LOAD = TW'(T_HLD - 1);

    // Sequencer state and latched command.
    state_t     state_reg, state_next;
    logic       write_reg, write_next;
    logic [6:0] addr_reg, addr_next;
    bit_idx_t   bit_reg, bit_next;
    logic [7:0] mask_reg, mask_next;      // bits still to be programmed, excluding the current one
    logic       err_reg, err_next;

    // Output registers.
    pins_t      pins_reg, pins_next;
    logic       strobe_reg, strobe_next;
    logic [9:0] a_reg, a_next;
    logic       ready_reg, ready_next;
    logic       busy_reg;
    logic       rsp_valid_reg, rsp_valid_next;
    logic [7:0] rsp_rdata_reg, rsp_rdata_next;
    logic       rsp_err_reg, rsp_err_next;

    // Shared phase timer.
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_zero;

    // Next-set-bit search.
    logic [7:0] mask_sel;
    logic [7:0] seen;
    logic [7:0] first_onehot;
    bit_idx_t   first_bit;

    logic       addr_oob;
    logic       handshake;

    assign addr_oob  = (int'(cmd_addr) >= NUM_BYTES);
    assign handshake = cmd_valid && ready_reg;

    efuse_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .srst     (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Priority encoder: isolate the lowest set bit of the selected mask.
    assign seen[0] = 1'b0;
    for (genvar gi = 1; gi < 8; gi++) begin : g_seen
        assign seen[gi] = seen[gi-1] | mask_sel[gi-1];
    end
    for (genvar gi = 0; gi < 8; gi++) begin : g_first
        assign first_onehot[gi] = mask_sel[gi] & ~seen[gi];
    end

    // Convert the isolated one-hot bit into an index.
    always_comb begin
        first_bit = '0;
        for (int i = 0; i < 8; i++) begin
            if (first_onehot[i]) begin
                first_bit = bit_idx_t'(i);
            end
        end
    end

    // Next-state logic: phase sequencing, command latching and timer control.
    always_comb begin
        state_next = state_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        bit_next   = bit_reg;
        mask_next  = mask_reg;
        err_next   = err_reg;
        timer_load = 1'b0;
        timer_val  = '0;
        mask_sel   = mask_reg;

        case (state_reg)
            IDLE: begin
                mask_sel = cmd_wdata;
                if (handshake) begin
                    write_next = cmd_write;
                    addr_next  = cmd_addr;
                    err_next   = addr_oob;
                    bit_next   = '0;
                    mask_next  = '0;
                    if (addr_oob || (cmd_write && (cmd_wdata == 8'h00))) begin
                        state_next = DONE;
                    end else begin
                        state_next = SETUP;
                        timer_load = 1'b1;
                        timer_val  = SU_LOAD;
                        if (cmd_write) begin
                            bit_next  = first_bit;
                            mask_next = cmd_wdata & ~first_onehot;
                        end
                    end
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    state_next = STROBE;
                    timer_load = 1'b1;
                    timer_val  = write_reg ? PGM_LOAD : RD_LOAD;
                end
            end
            STROBE: begin
                if (timer_zero) begin
                    state_next = HOLD;
                    timer_load = 1'b1;
                    timer_val  = HLD_LOAD;
                end
            end
            HOLD: begin
                if (timer_zero) begin
                    if (write_reg && (mask_reg != 8'h00)) begin
                        // Mode pins stay asserted; only the bit field of the address moves.
                        state_next = SETUP;
                        timer_load = 1'b1;
                        timer_val  = SU_LOAD;
                        bit_next   = first_bit;
                        mask_next  = mask_reg & ~first_onehot;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every pin leaves a register.
    always_comb begin
        pins_next      = PINS_IDLE;
        strobe_next    = 1'b0;
        a_next         = '0;
        ready_next     = (state_next == IDLE);
        rsp_valid_next = (state_next == DONE);
        rsp_err_next   = rsp_err_reg;
        rsp_rdata_next = rsp_rdata_reg;

        case (state_next)
            SETUP, STROBE, HOLD: begin
                pins_next   = write_next ? PINS_PGM : PINS_READ;
                a_next      = efuse_a_pack(bit_next, addr_next);
                strobe_next = (state_next == STROBE);
            end
            DONE: begin
                // Entering DONE from HOLD is the last hold cycle: macro data is valid here.
                rsp_err_next   = err_next;
                rsp_rdata_next = (!write_next && !err_next) ? efuse_q : 8'h00;
            end
            default: begin
            end
        endcase
    end

    // State and command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            bit_reg   <= '0;
            mask_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            bit_reg   <= bit_next;
            mask_reg  <= mask_next;
            err_reg   <= err_next;
        end
    end

    // Output registers; reset drops strobe and returns pins to idle immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            pins_reg      <= PINS_IDLE;
            strobe_reg    <= 1'b0;
            a_reg         <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            pins_reg      <= pins_next;
            strobe_reg    <= strobe_next;
            a_reg         <= a_next;
            ready_reg     <= ready_next;
            busy_reg      <= ~ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign cmd_ready    = ready_reg;
    assign busy         = busy_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rsp_rdata_reg;
    assign rsp_err      = rsp_err_reg;
    assign efuse_csb    = pins_reg.csb;
    assign efuse_load   = pins_reg.load;
    assign efuse_vddq   = pins_reg.vddq;
    assign efuse_pgenb  = pins_reg.pgenb;
    assign efuse_strobe = strobe_reg;
    assign efuse_a      = a_reg;

endmodule

// File: tb/tb_efuse_ctrl.sv
// Bench for efuse_ctrl: behavioural eFuse macro, strobe-pulse monitor and a
// reference fuse array driving expected responses, latencies and pulse trains.
module tb_efuse_ctrl;

    localparam int NB   = 10;
    localparam int TSU  = 2;
    localparam int TRD  = 4;
    localparam int TPGM = 100;
    localparam int THLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       efuse_csb, efuse_strobe, efuse_load, efuse_vddq, efuse_pgenb;
    logic [9:0] efuse_a;
    logic [7:0] efuse_q;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int         width;
        logic [9:0] a;
        logic       csb;
        logic       load;
        logic       vddq;
        logic       pgenb;
        logic       stable;
    } pulse_t;

    pulse_t pulses[$];
    int     csb_low_cycles = 0;
    logic [7:0] ref_mem [128];

    efuse_ctrl #(
        .NUM_BYTES(NB), .T_SU(TSU), .T_RD(TRD), .T_PGM(TPGM), .T_HLD(THLD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .efuse_csb(efuse_csb), .efuse_strobe(efuse_strobe), .efuse_load(efuse_load),
        .efuse_vddq(efuse_vddq), .efuse_pgenb(efuse_pgenb), .efuse_a(efuse_a),
        .efuse_q(efuse_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        if (i == 0) return 8'h00;
        if (i == 1) return 8'hFF;
        return 8'((i * 37 + 11) & 8'h5A);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural macro: read data appears after STROBE falls; a bit blows only on a full-length pulse.
    initial begin
        logic [7:0] mac [128];
        int         wcnt;
        logic [9:0] cap_a;
        logic       cap_rd, cap_pgm;
        for (int i = 0; i < 128; i++) mac[i] = init_val(i);
        efuse_q = 8'h00;
        wcnt = 0; cap_a = '0; cap_rd = 1'b0; cap_pgm = 1'b0;
        forever begin
            @(negedge clk);
            if (efuse_strobe) begin
                if (wcnt == 0) begin
                    cap_a   = efuse_a;
                    cap_rd  = !efuse_csb && efuse_load && !efuse_vddq && efuse_pgenb;
                    cap_pgm = !efuse_csb && !efuse_load && efuse_vddq && !efuse_pgenb;
                    efuse_q = 8'($urandom);
                end
                wcnt++;
            end else if (wcnt > 0) begin
                if (cap_rd) efuse_q = mac[cap_a[6:0]];
                if (cap_pgm && wcnt >= TPGM) mac[cap_a[6:0]][cap_a[9:7]] = 1'b1;
                wcnt = 0;
            end
        end
    end

    // Pulse monitor: records each strobe pulse with the pins seen at its start.
    initial begin
        pulse_t cur;
        cur.width = 0; cur.a = '0; cur.csb = 1'b1; cur.load = 1'b0;
        cur.vddq = 1'b0; cur.pgenb = 1'b1; cur.stable = 1'b1;
        forever begin
            @(negedge clk);
            if (!efuse_csb) csb_low_cycles++;
            if (efuse_strobe) begin
                if (cur.width == 0) begin
                    cur.a = efuse_a; cur.csb = efuse_csb; cur.load = efuse_load;
                    cur.vddq = efuse_vddq; cur.pgenb = efuse_pgenb; cur.stable = 1'b1;
                end else if (cur.a !== efuse_a || cur.csb !== efuse_csb || cur.load !== efuse_load ||
                             cur.vddq !== efuse_vddq || cur.pgenb !== efuse_pgenb) begin
                    cur.stable = 1'b0;
                end
                cur.width++;
            end else if (cur.width > 0) begin
                pulses.push_back(cur);
                cur.width = 0;
            end
        end
    end

    // Issue one command and wait for its response; lat is cycles from handshake cycle.
    task automatic issue(input logic w, input logic [6:0] ad, input logic [7:0] wd,
                         output int lat, output logic [7:0] rd, output logic er,
                         output int pbase, output int cbase);
        int n;
        int c0;
        lat = -1; rd = 8'h00; er = 1'b0;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        pbase = pulses.size();
        cbase = csb_low_cycles;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = ad; cmd_wdata = wd;
        c0 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom);
        for (int i = 0; i < 2000; i++) begin
            if (rsp_valid) begin
                lat = cyc - c0; rd = rsp_rdata; er = rsp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({efuse_csb, efuse_strobe, efuse_load, efuse_vddq, efuse_pgenb} !== 5'b10001) begin
            failures++;
            $display("FAIL reset_pins got=%b want=10001",
                     {efuse_csb, efuse_strobe, efuse_load, efuse_vddq, efuse_pgenb});
        end
        checks++;
        if (efuse_a !== 10'd0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp a=%h v=%b d=%h e=%b want 0", efuse_a, rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_read_after_reset();
        int lat, pb, cb;
        logic [7:0] rd;
        logic er;
        issue(1'b0, 7'd1, 8'h00, lat, rd, er, pb, cb);
        $display("read addr=1 lat=%0d rdata=%h err=%b", lat, rd, er);
        checks++;
        if (lat !== 1 + TSU + TRD + THLD) begin failures++; $display("FAIL read1_lat got=%0d want=%0d", lat, 1 + TSU + TRD + THLD); end
        checks++;
        if (rd !== 8'hFF || er !== 1'b0) begin failures++; $display("FAIL read1_data got=%h/%b want=ff/0", rd, er); end
        checks++;
        if (pulses.size() - pb !== 1) begin
            failures++; $display("FAIL read1_npulse got=%0d want=1", pulses.size() - pb);
        end else begin
            checks++;
            if (pulses[pb].width !== TRD || pulses[pb].load !== 1'b1 || pulses[pb].vddq !== 1'b0 ||
                pulses[pb].pgenb !== 1'b1 || pulses[pb].csb !== 1'b0 || pulses[pb].a !== 10'd1 || !pulses[pb].stable) begin
                failures++;
                $display("FAIL read1_pulse width=%0d load=%b vddq=%b a=%h want width=%0d load=1 vddq=0 a=001",
                         pulses[pb].width, pulses[pb].load, pulses[pb].vddq, pulses[pb].a, TRD);
            end
        end
    endtask

    task automatic test_program_a5();
        int lat, pb, cb;
        logic [7:0] rd;
        logic er;
        int exp_bits[4] = '{0, 2, 5, 7};
        issue(1'b1, 7'd0, 8'hA5, lat, rd, er, pb, cb);
        $display("program addr=0 wdata=a5 lat=%0d err=%b", lat, er);
        ref_mem[0] = ref_mem[0] | 8'hA5;
        checks++;
        if (lat !== 1 + 4 * (TSU + TPGM + THLD)) begin failures++; $display("FAIL pgm_lat got=%0d want=%0d", lat, 1 + 4 * (TSU + TPGM + THLD)); end
        checks++;
        if (rd !== 8'h00 || er !== 1'b0) begin failures++; $display("FAIL pgm_rsp got=%h/%b want=00/0", rd, er); end
        checks++;
        if (pulses.size() - pb !== 4) begin
            failures++; $display("FAIL pgm_npulse got=%0d want=4", pulses.size() - pb);
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (pulses[pb+j].width !== TPGM || int'(pulses[pb+j].a[9:7]) !== exp_bits[j] ||
                    pulses[pb+j].a[6:0] !== 7'd0 || pulses[pb+j].vddq !== 1'b1 || pulses[pb+j].load !== 1'b0 ||
                    pulses[pb+j].pgenb !== 1'b0 || !pulses[pb+j].stable) begin
                    failures++;
                    $display("FAIL pgm_pulse%0d width=%0d a=%h vddq=%b load=%b want width=%0d bit=%0d vddq=1 load=0",
                             j, pulses[pb+j].width, pulses[pb+j].a, pulses[pb+j].vddq, pulses[pb+j].load, TPGM, exp_bits[j]);
                end
            end
        end
        issue(1'b0, 7'd0, 8'h00, lat, rd, er, pb, cb);
        $display("read addr=0 lat=%0d rdata=%h", lat, rd);
        checks++;
        if (rd !== 8'hA5) begin failures++; $display("FAIL pgm_readback got=%h want=a5", rd); end
    endtask

    task automatic test_zero_write();
        int lat, pb, cb;
        logic [7:0] rd;
        logic er;
        issue(1'b1, 7'd2, 8'h00, lat, rd, er, pb, cb);
        $display("program addr=2 wdata=00 lat=%0d err=%b", lat, er);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 8'h00) begin failures++; $display("FAIL zero_write got lat=%0d err=%b d=%h want 1/0/00", lat, er, rd); end
        checks++;
        if (csb_low_cycles !== cb || pulses.size() !== pb) begin failures++; $display("FAIL zero_write_pins csb_low=%0d pulses=%0d want 0/0", csb_low_cycles - cb, pulses.size() - pb); end
    endtask

    task automatic test_out_of_range();
        int lat, pb, cb;
        logic [7:0] rd;
        logic er;
        issue(1'b0, 7'(NB), 8'h00, lat, rd, er, pb, cb);
        $display("read addr=%0d lat=%0d rdata=%h err=%b", NB, lat, rd, er);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 8'h00) begin failures++; $display("FAIL oob got lat=%0d err=%b d=%h want 1/1/00", lat, er, rd); end
        checks++;
        if (csb_low_cycles !== cb) begin failures++; $display("FAIL oob_csb low_cycles=%0d want=0", csb_low_cycles - cb); end
    endtask

    task automatic test_reset_mid_program();
        int n;
        int nrsp;
        int notready;
        int lat, pb, cb;
        logic [7:0] rd;
        logic er;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'd6; cmd_wdata = 8'h03;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!efuse_strobe && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (efuse_strobe !== 1'b1) begin failures++; $display("FAIL rstmid_strobe_start got=%b want=1", efuse_strobe); end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("reset during program strobe addr=6");
        checks++;
        if ({efuse_strobe, efuse_csb, efuse_vddq, efuse_pgenb, efuse_load} !== 5'b01010) begin
            failures++;
            $display("FAIL rstmid_pins strobe/csb/vddq/pgenb/load=%b want=01010",
                     {efuse_strobe, efuse_csb, efuse_vddq, efuse_pgenb, efuse_load});
        end
        @(negedge clk);
        rst = 1'b0;
        nrsp = 0; notready = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
            if (!cmd_ready) notready++;
        end
        checks++;
        if (nrsp !== 0) begin failures++; $display("FAIL rstmid_rsp got=%0d responses want=0", nrsp); end
        checks++;
        if (notready !== 0) begin failures++; $display("FAIL rstmid_ready not-ready cycles=%0d want=0", notready); end
        issue(1'b0, 7'd6, 8'h00, lat, rd, er, pb, cb);
        checks++;
        if (rd !== ref_mem[6]) begin failures++; $display("FAIL rstmid_readback got=%h want=%h", rd, ref_mem[6]); end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        int lat1;
        int bad_ready;
        logic [7:0] rd1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'd4; cmd_wdata = 8'h00;
        c0 = cyc;
        @(negedge clk);
        cmd_addr = 7'd1;
        bad_ready = 0; lat1 = -1; rd1 = 8'h00;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) bad_ready++;
            if (rsp_valid) begin lat1 = cyc - c0; rd1 = rsp_rdata; break; end
            @(negedge clk);
        end
        $display("b2b first read addr=4 lat=%0d rdata=%h", lat1, rd1);
        checks++;
        if (bad_ready !== 0) begin failures++; $display("FAIL b2b_busy_ready ready cycles=%0d want=0", bad_ready); end
        checks++;
        if (lat1 !== 1 + TSU + TRD + THLD || rd1 !== ref_mem[4]) begin failures++; $display("FAIL b2b_first got lat=%0d d=%h want %0d/%h", lat1, rd1, 1 + TSU + TRD + THLD, ref_mem[4]); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept ready=%b want=1", cmd_ready); end
        c1 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat1 = -1; rd1 = 8'h00;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin lat1 = cyc - c1; rd1 = rsp_rdata; break; end
            @(negedge clk);
        end
        $display("b2b second read addr=1 lat=%0d rdata=%h", lat1, rd1);
        checks++;
        if (lat1 !== 1 + TSU + TRD + THLD || rd1 !== ref_mem[1]) begin failures++; $display("FAIL b2b_second got lat=%0d d=%h want %0d/%h", lat1, rd1, 1 + TSU + TRD + THLD, ref_mem[1]); end
    endtask

    task automatic test_random();
        int lat, pb, cb, k, exp_lat, np, bit_i;
        logic [7:0] rd, exp_rd;
        logic er, w, oob;
        logic [6:0] ad;
        logic [7:0] wd;
        for (int t = 0; t < 14; t++) begin
            w   = ($urandom_range(0, 9) < 4);
            ad  = 7'($urandom_range(0, NB + 2));
            wd  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            oob = (int'(ad) >= NB);
            k   = $countones(wd);
            if (oob || (w && wd == 8'h00)) exp_lat = 1;
            else if (w) exp_lat = 1 + k * (TSU + TPGM + THLD);
            else exp_lat = 1 + TSU + TRD + THLD;
            exp_rd = (!w && !oob) ? ref_mem[ad] : 8'h00;
            issue(w, ad, wd, lat, rd, er, pb, cb);
            $display("rand %0d write=%b addr=%0d wdata=%h lat=%0d rdata=%h err=%b", t, w, ad, wd, lat, rd, er);
            checks++;
            if (lat !== exp_lat || rd !== exp_rd || er !== oob) begin
                failures++;
                $display("FAIL rand%0d_rsp got lat=%0d d=%h e=%b want %0d/%h/%b", t, lat, rd, er, exp_lat, exp_rd, oob);
            end
            np = oob ? 0 : (w ? k : 1);
            checks++;
            if (pulses.size() - pb !== np) begin
                failures++;
                $display("FAIL rand%0d_npulse got=%0d want=%0d", t, pulses.size() - pb, np);
            end else begin
                bit_i = 0;
                for (int j = 0; j < np; j++) begin
                    if (w) while (!wd[bit_i]) bit_i++;
                    checks++;
                    if (pulses[pb+j].a !== {3'(bit_i), ad} || pulses[pb+j].width !== (w ? TPGM : TRD) ||
                        pulses[pb+j].load !== !w || pulses[pb+j].vddq !== w || pulses[pb+j].pgenb !== !w ||
                        pulses[pb+j].csb !== 1'b0 || !pulses[pb+j].stable) begin
                        failures++;
                        $display("FAIL rand%0d_pulse%0d a=%h width=%0d load=%b vddq=%b want a=%h width=%0d",
                                 t, j, pulses[pb+j].a, pulses[pb+j].width, pulses[pb+j].load, pulses[pb+j].vddq,
                                 {3'(bit_i), ad}, w ? TPGM : TRD);
                    end
                    bit_i++;
                end
            end
            if (w && !oob) ref_mem[ad] = ref_mem[ad] | wd;
        end
        for (int i = 0; i < NB; i++) begin
            issue(1'b0, 7'(i), 8'h00, lat, rd, er, pb, cb);
            $display("sweep read addr=%0d rdata=%h", i, rd);
            checks++;
            if (rd !== ref_mem[i] || er !== 1'b0) begin failures++; $display("FAIL sweep%0d got=%h/%b want=%h/0", i, rd, er, ref_mem[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        test_reset();
        test_read_after_reset();
        test_program_a5();
        test_zero_write();
        test_out_of_range();
        test_reset_mid_program();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
